// File: rtl/instr_exec_unit_if.sv
// Register-read and result-handshake bus between instr_exec_unit and its neighbours.
// The master side is the execution unit; the slave side is the register file plus the consumer.
interface instr_exec_unit_if #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int RES_W  = 64
);
  logic [ADDR_W-1:0]      read_pointer;
  logic [4+2*OP_W-1:0]    instruction_word;
  logic                   result_valid;
  logic                   result_ready;
  logic signed [RES_W-1:0] result;
  logic [ADDR_W-1:0]      result_ptr;
  logic [3:0]             result_opc;
  logic                   div_zero;
  logic                   illegal_opc;

  modport master (
    output read_pointer,
    input  instruction_word,
    output result_valid,
    input  result_ready,
    output result,
    output result_ptr,
    output result_opc,
    output div_zero,
    output illegal_opc
  );

  modport slave (
    input  read_pointer,
    output instruction_word,
    input  result_valid,
    output result_ready,
    input  result,
    input  result_ptr,
    input  result_opc,
    input  div_zero,
    input  illegal_opc
  );
endinterface

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a register address range, executes each signed opcode
// and emits one result per instruction over a valid/ready port.
module instr_exec_unit #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int RES_W  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_ptr,
  input  logic [ADDR_W-1:0] last_ptr,
  output logic              busy,
  output logic              done,
  instr_exec_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_W-1:0]       last_q;
  logic [3:0]              opc_q;
  logic signed [OP_W-1:0]  a_q;
  logic signed [OP_W-1:0]  b_q;
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] res_calc;
  logic                    dz_calc;
  logic                    il_calc;
  logic                    at_last;

  // Operands are widened first so MULT is exact and -2^31 / -1 cannot overflow.
  assign a_ext   = {{(RES_W-OP_W){a_q[OP_W-1]}}, a_q};
  assign b_ext   = {{(RES_W-OP_W){b_q[OP_W-1]}}, b_q};
  assign at_last = (bus.read_pointer == last_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    state_next = OUT;
      OUT:     if (bus.result_ready) state_next = at_last ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_calc = '0;
    dz_calc  = 1'b0;
    il_calc  = 1'b0;
    case (opc_q)
      4'd0: res_calc = '0;
      4'd1: res_calc = a_ext;
      4'd2: res_calc = b_ext;
      4'd3: res_calc = a_ext + b_ext;
      4'd4: res_calc = a_ext - b_ext;
      4'd5: res_calc = a_ext * b_ext;
      4'd6: if (b_q == '0) dz_calc = 1'b1; else res_calc = a_ext / b_ext;
      4'd7: if (b_q == '0) dz_calc = 1'b1; else res_calc = a_ext % b_ext;
      default: il_calc = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.read_pointer <= '0;
      bus.result       <= '0;
      bus.result_ptr   <= '0;
      bus.result_opc   <= '0;
      bus.result_valid <= 1'b0;
      bus.div_zero     <= 1'b0;
      bus.illegal_opc  <= 1'b0;
      last_q           <= '0;
      opc_q            <= '0;
      a_q              <= '0;
      b_q              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            last_q           <= last_ptr;
            bus.read_pointer <= first_ptr;
          end
        end
        FETCH: {opc_q, a_q, b_q} <= bus.instruction_word;
        EXEC: begin
          bus.result       <= res_calc;
          bus.result_ptr   <= bus.read_pointer;
          bus.result_opc   <= opc_q;
          bus.div_zero     <= dz_calc;
          bus.illegal_opc  <= il_calc;
          bus.result_valid <= 1'b1;
        end
        OUT: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            if (!at_last) bus.read_pointer <= bus.read_pointer + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: constant vector table, hand-timed corner
// sequences and randomized runs scored against a plain-arithmetic reference model.
module tb_instr_exec_unit;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 32;
  localparam int RES_W  = 64;
  localparam int WORD_W = 4 + 2*OP_W;

  typedef struct {
    logic [4:0] ptr;
    logic [3:0] opc;
    longint     res;
    bit         dz;
    bit         il;
  } exp_t;

  typedef struct {
    logic [3:0] opc;
    int         a;
    int         b;
    longint     res;
    bit         dz;
    bit         il;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [4:0] first_ptr = '0;
  logic [4:0] last_ptr = '0;
  logic       busy;
  logic       done;
  logic [WORD_W-1:0] regs [32];
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t got_q[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  instr_exec_unit_if #(.ADDR_W(ADDR_W), .OP_W(OP_W), .RES_W(RES_W)) bus ();

  assign bus.instruction_word = regs[bus.read_pointer];
  assign bus.result_ready     = ready;

  instr_exec_unit #(.ADDR_W(ADDR_W), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .first_ptr (first_ptr),
    .last_ptr  (last_ptr),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  function automatic logic [WORD_W-1:0] mk(input logic [3:0] opc, input int a, input int b);
    return {opc, a, b};
  endfunction

  // Reference behaviour straight from the opcode table using 64-bit integer arithmetic.
  function automatic exp_t model(input logic [4:0] p, input logic [WORD_W-1:0] w);
    exp_t e;
    int a;
    int b;
    a = w[63:32];
    b = w[31:0];
    e.ptr = p; e.opc = w[67:64]; e.res = 0; e.dz = 0; e.il = 0;
    case (e.opc)
      4'd0: e.res = 0;
      4'd1: e.res = longint'(a);
      4'd2: e.res = longint'(b);
      4'd3: e.res = longint'(a) + longint'(b);
      4'd4: e.res = longint'(a) - longint'(b);
      4'd5: e.res = longint'(a) * longint'(b);
      4'd6: if (b == 0) e.dz = 1; else e.res = longint'(a) / longint'(b);
      4'd7: if (b == 0) e.dz = 1; else e.res = longint'(a) % longint'(b);
      default: e.il = 1;
    endcase
    return e;
  endfunction

  function automatic logic [127:0] pk(input exp_t e);
    return 128'({e.ptr, e.opc, e.dz, e.il, e.res});
  endfunction

  function automatic logic [127:0] dut_result();
    return 128'({bus.result_ptr, bus.result_opc, bus.div_zero, bus.illegal_opc, bus.result});
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({bus.read_pointer, bus.result, bus.result_ptr, bus.result_opc,
                 bus.result_valid, bus.div_zero, bus.illegal_opc, busy, done});
  endfunction

  function automatic int rnd_op();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Leaves the bench at the falling edge right after the edge that samples start.
  task automatic applyStimulus(input logic [4:0] first, input logic [4:0] last);
    @(negedge clk);
    first_ptr = first;
    last_ptr  = last;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for cycles 3..7.
  task automatic run_range(input logic [4:0] first, input logic [4:0] last, input int mode, input bit inject);
    int n;
    bit seen_done;
    exp_t g;
    exp_q.delete();
    got_q.delete();
    n = int'(5'(last - first)) + 1;
    for (int k = 0; k < n; k++) begin
      logic [4:0] p;
      p = 5'(first + 5'(k));
      exp_q.push_back(model(p, regs[p]));
    end
    ready = 1'b1;
    applyStimulus(first, last);
    seen_done = 0;
    for (int cyc = 1; cyc <= 3*n + 200 && !seen_done; cyc++) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = !(cyc >= 3 && cyc <= 7);
      endcase
      if (inject) begin
        start = (cyc == 5);
        if (cyc == 5) begin
          first_ptr = first + 5'd9;
          last_ptr  = first + 5'd9;
        end
      end
      if (bus.result_valid) begin
        if (exp_q.size() == 0) checkOutput("extra_result", 1, 0);
        else begin
          checkOutput("result", dut_result(), pk(exp_q[0]));
          checkOutput("rd_ptr_hold", 128'(bus.read_pointer), 128'(exp_q[0].ptr));
          if (ready) begin
            g.ptr = bus.result_ptr; g.opc = bus.result_opc; g.res = bus.result;
            g.dz = bus.div_zero; g.il = bus.illegal_opc;
            got_q.push_back(g);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        seen_done = 1;
        checkOutput("remaining", 128'(exp_q.size()), 0);
        checkOutput("busy_in_done", 128'(busy), 1);
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen_done) checkOutput("run_timeout", 0, 1);
    @(negedge clk);
    checkOutput("idle_after", 128'({busy, done}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    vecs[0]  = '{4'd0, -7, 2, 0, 0, 0};
    vecs[1]  = '{4'd1, -7, 2, -7, 0, 0};
    vecs[2]  = '{4'd2, -7, 2, 2, 0, 0};
    vecs[3]  = '{4'd3, -7, 2, -5, 0, 0};
    vecs[4]  = '{4'd4, -7, 2, -9, 0, 0};
    vecs[5]  = '{4'd5, -7, 2, -14, 0, 0};
    vecs[6]  = '{4'd6, -7, 2, -3, 0, 0};
    vecs[7]  = '{4'd7, -7, 2, -1, 0, 0};
    vecs[8]  = '{4'd6, 5, 0, 0, 1, 0};
    vecs[9]  = '{4'd9, 3, 4, 0, 0, 1};
    vecs[10] = '{4'd6, int'(32'h8000_0000), -1, 64'sd2147483648, 0, 0};
    vecs[11] = '{4'd5, 32'h7fff_ffff, 32'h7fff_ffff, 64'sd4611686014132420609, 0, 0};
    vecs[12] = '{4'd7, -7, 0, 0, 1, 0};

    // Reset state and a start pulse that no clock edge sees.
    first_ptr = 5'd5;
    last_ptr  = 5'd5;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", all_outs(), 0);
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    #2 start = 1'b0;
    @(negedge clk);
    checkOutput("start_no_edge", 128'({busy, bus.read_pointer, bus.result_valid}), 0);

    // Single ADD with exact cycle timing.
    regs[2] = mk(4'd3, -5, 12);
    ready = 1'b1;
    applyStimulus(5'd2, 5'd2);
    checkOutput("single_rd_ptr", 128'(bus.read_pointer), 2);
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("single_valid_c%0d", k), 128'(bus.result_valid), 128'(k == 3));
      checkOutput($sformatf("single_done_c%0d", k), 128'(done), 128'(k == 4));
      checkOutput($sformatf("single_busy_c%0d", k), 128'(busy), 128'(k <= 4));
      if (k == 3) checkOutput("single_result", 128'({bus.result_ptr, bus.result}), 128'({5'd2, 64'sd7}));
      @(negedge clk);
    end

    // Vector table: every opcode plus the divide/illegal/overflow edge cases.
    for (int i = 0; i < 13; i++) regs[i] = mk(vecs[i].opc, vecs[i].a, vecs[i].b);
    run_range(5'd0, 5'd12, 0, 0);
    for (int i = 0; i < 13; i++) begin
      exp_t e;
      e.ptr = 5'(i); e.opc = vecs[i].opc; e.res = vecs[i].res; e.dz = vecs[i].dz; e.il = vecs[i].il;
      if (i < got_q.size()) checkOutput($sformatf("vec%0d", i), pk(got_q[i]), pk(e));
      else checkOutput($sformatf("vec%0d_missing", i), 0, 1);
    end

    // Backpressure on a run of three.
    regs[4] = mk(4'd3, 1, 2);
    regs[5] = mk(4'd4, 1, 2);
    regs[6] = mk(4'd5, -3, 4);
    run_range(5'd4, 5'd6, 2, 0);
    checkOutput("bp_count", 128'(got_q.size()), 3);

    // Wrapping range with a stray start mid-run.
    regs[30] = mk(4'd3, 100, -1);
    regs[31] = mk(4'd4, 0, 5);
    regs[0]  = mk(4'd5, -3, -3);
    regs[1]  = mk(4'd7, -7, 2);
    run_range(5'd30, 5'd1, 1, 1);
    checkOutput("wrap_count", 128'(got_q.size()), 4);

    // Asynchronous reset while a result is stalled in OUT.
    ready = 1'b0;
    applyStimulus(5'd3, 5'd6);
    for (int i = 0; i < 10 && !bus.result_valid; i++) @(negedge clk);
    checkOutput("midrun_valid", 128'(bus.result_valid), 1);
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset", all_outs(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_range(5'd3, 5'd6, 0, 0);

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 9) == 0) regs[i] = mk(4'd6, int'(32'h8000_0000), -1);
        else regs[i] = mk(4'($urandom_range(0, 11)), rnd_op(), ($urandom_range(0, 5) == 0) ? 0 : rnd_op());
      end
      run_range(5'($urandom), 5'($urandom), 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
